// File: rtl/wb_mux_tmo.sv
// Wishbone 1:N decoder/router with registered decode and response watchdog.
// Optional macro WB_MUX_TIMEOUT_EN enables the per-transfer timeout error.
module wb_mux_tmo #(
    parameter int                   dw         = 32,
    parameter int                   aw         = 32,
    parameter int                   num_slaves = 2,
    parameter logic [num_slaves*aw-1:0] MATCH_ADDR = '0,
    parameter logic [num_slaves*aw-1:0] MATCH_MASK = '0,
    parameter int                   TIMEOUT    = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [aw-1:0]            wbm_adr_i,
    input  logic [dw-1:0]            wbm_dat_i,
    input  logic [3:0]               wbm_sel_i,
    input  logic                     wbm_we_i,
    input  logic                     wbm_cyc_i,
    input  logic                     wbm_stb_i,
    input  logic [2:0]               wbm_cti_i,
    input  logic [1:0]               wbm_bte_i,
    output logic [dw-1:0]            wbm_dat_o,
    output logic                     wbm_ack_o,
    output logic                     wbm_err_o,
    output logic                     wbm_rty_o,
    output logic [num_slaves*aw-1:0] wbs_adr_o,
    output logic [num_slaves*dw-1:0] wbs_dat_o,
    output logic [num_slaves*4-1:0]  wbs_sel_o,
    output logic [num_slaves*3-1:0]  wbs_cti_o,
    output logic [num_slaves*2-1:0]  wbs_bte_o,
    output logic [num_slaves-1:0]    wbs_we_o,
    output logic [num_slaves-1:0]    wbs_cyc_o,
    output logic [num_slaves-1:0]    wbs_stb_o,
    input  logic [num_slaves*dw-1:0] wbs_dat_i,
    input  logic [num_slaves-1:0]    wbs_ack_i,
    input  logic [num_slaves-1:0]    wbs_err_i,
    input  logic [num_slaves-1:0]    wbs_rty_i
);

    localparam int SW = (num_slaves > 1) ? $clog2(num_slaves) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_sel;

    logic          w_hit;
    logic [SW-1:0] w_idx;
    logic          w_act;
    logic          w_s_ack;
    logic          w_s_err;
    logic          w_s_rty;
    logic          w_rsp;
    logic          w_burst;
    logic          w_tmo;

    assign wbs_adr_o = {num_slaves{wbm_adr_i}};
    assign wbs_dat_o = {num_slaves{wbm_dat_i}};
    assign wbs_sel_o = {num_slaves{wbm_sel_i}};
    assign wbs_cti_o = {num_slaves{wbm_cti_i}};
    assign wbs_bte_o = {num_slaves{wbm_bte_i}};
    assign wbs_we_o  = {num_slaves{wbm_we_i}};

    assign wbm_dat_o = wbs_dat_i[r_sel*dw +: dw];

    assign w_act   = (r_state == S_ACTIVE);
    assign w_s_ack = wbs_ack_i[r_sel];
    assign w_s_err = wbs_err_i[r_sel];
    assign w_s_rty = wbs_rty_i[r_sel];
    assign w_rsp   = w_s_ack | w_s_err | w_s_rty;
    assign w_burst = (wbm_cti_i == 3'b001) || (wbm_cti_i == 3'b010);

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = num_slaves - 1; i >= 0; i--) begin
            if ((wbm_adr_i & MATCH_MASK[i*aw +: aw]) == MATCH_ADDR[i*aw +: aw]) begin
                w_hit = 1'b1;
                w_idx = SW'(i);
            end
        end
    end

`ifdef WB_MUX_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_tmo = w_act & wbm_cyc_i & wbm_stb_i & ~w_rsp
                 & (r_cnt == 16'(TIMEOUT - 1));

    // Watchdog: counts unanswered strobe cycles of the current transfer
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_cnt <= '0;
        end else if (!w_act) begin
            r_cnt <= '0;
        end else if (w_rsp || w_tmo || !wbm_cyc_i) begin
            r_cnt <= '0;
        end else if (wbm_stb_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT;
    assign w_tmo        = 1'b0;
`endif

    // Only the latched slave sees cyc/stb; an expiring transfer is cut off
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        if (w_act && !w_tmo) begin
            wbs_cyc_o[r_sel] = wbm_cyc_i;
            wbs_stb_o[r_sel] = wbm_stb_i;
        end
    end

    assign wbm_ack_o = w_act & w_s_ack;
    assign wbm_rty_o = w_act & w_s_rty;
    assign wbm_err_o = (w_act & (w_s_err | w_tmo))
                     | ((r_state == S_ERR) & wbm_cyc_i);

    // Transfer FSM: decode in IDLE, route in ACTIVE, one-cycle miss error
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (w_hit) begin
                            r_sel   <= w_idx;
                            r_state <= S_ACTIVE;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!wbm_cyc_i) begin
                        r_state <= S_IDLE;
                    end else if (w_rsp) begin
                        if (!(w_s_ack && w_burst)) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mux_tmo.sv
// Directed bench for wb_mux_tmo: vector table plus burst, timeout, reset.
// Timeout sequences follow WB_MUX_TIMEOUT_EN as the DUT does.
module tb_wb_mux_tmo;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_cyc;
    logic        m_stb;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [31:0] m_dat_o;
    logic        m_ack;
    logic        m_err;
    logic        m_rty;
    logic [63:0] s_adr;
    logic [63:0] s_dat;
    logic [7:0]  s_sel;
    logic [5:0]  s_cti;
    logic [3:0]  s_bte;
    logic [1:0]  s_we;
    logic [1:0]  s_cyc;
    logic [1:0]  s_stb;
    logic [63:0] s_dat_i;
    logic [1:0]  s_ack;
    logic [1:0]  s_err;
    logic [1:0]  s_rty;

    int errors = 0;
    int checks = 0;

    wb_mux_tmo #(
        .dw        (32),
        .aw        (32),
        .num_slaves(2),
        .MATCH_ADDR({32'h1000_0000, 32'h0000_0000}),
        .MATCH_MASK({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT   (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbm_adr_i(m_adr),
        .wbm_dat_i(m_dat),
        .wbm_sel_i(m_sel),
        .wbm_we_i (m_we),
        .wbm_cyc_i(m_cyc),
        .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti),
        .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o),
        .wbm_ack_o(m_ack),
        .wbm_err_o(m_err),
        .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr),
        .wbs_dat_o(s_dat),
        .wbs_sel_o(s_sel),
        .wbs_cti_o(s_cti),
        .wbs_bte_o(s_bte),
        .wbs_we_o (s_we),
        .wbs_cyc_o(s_cyc),
        .wbs_stb_o(s_stb),
        .wbs_dat_i(s_dat_i),
        .wbs_ack_i(s_ack),
        .wbs_err_i(s_err),
        .wbs_rty_i(s_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        int          tgt;
        logic [2:0]  s_rsp;
        int          dly;
        logic [31:0] rdat;
        logic [1:0]  exp_stb;
        logic [2:0]  exp_rsp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_cti = 3'b000;
        s_ack = 2'b00;
        s_err = 2'b00;
        s_rty = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        m_adr = v.adr;
        m_we  = v.we;
        m_dat = v.wdat;
        m_cti = 3'b000;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        #1;
        chk("idle_stb", {62'd0, s_stb}, 64'd0);
        chk("idle_rsp", {61'd0, m_ack, m_err, m_rty}, 64'd0);
        chk("bc_adr", s_adr, {2{v.adr}});
        chk("bc_dat", s_dat, {2{v.wdat}});
        chk("bc_we", {62'd0, s_we}, {62'd0, {2{v.we}}});
        @(posedge clk); #1;
        chk("stb", {62'd0, s_stb}, {62'd0, v.exp_stb});
        chk("cyc", {62'd0, s_cyc}, {62'd0, v.exp_stb});
        if (v.tgt < 0) begin
            chk("miss_rsp", {61'd0, m_ack, m_err, m_rty}, {61'd0, v.exp_rsp});
        end else begin
            for (int k = 0; k < v.dly; k++) begin
                chk("wait_rsp", {61'd0, m_ack, m_err, m_rty}, 64'd0);
                @(posedge clk); #1;
                chk("wait_stb", {62'd0, s_stb}, {62'd0, v.exp_stb});
            end
            s_dat_i = {~v.rdat, ~v.rdat};
            if (v.tgt == 1) s_dat_i[63:32] = v.rdat;
            else            s_dat_i[31:0]  = v.rdat;
            s_ack[v.tgt] = v.s_rsp[2];
            s_err[v.tgt] = v.s_rsp[1];
            s_rty[v.tgt] = v.s_rsp[0];
            #1;
            chk("rsp", {61'd0, m_ack, m_err, m_rty}, {61'd0, v.exp_rsp});
            chk("rdat", {32'd0, m_dat_o}, {32'd0, v.rdat});
        end
        @(posedge clk); #1;
        s_ack = 2'b00;
        s_err = 2'b00;
        s_rty = 2'b00;
        #1;
        chk("back_idle_stb", {62'd0, s_stb}, 64'd0);
        chk("back_idle_rsp", {61'd0, m_ack, m_err, m_rty}, 64'd0);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(posedge clk); #1;
        chk("cyc_low_err", {63'd0, m_err}, 64'd0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h1000_0004, 1'b0, 32'h0, 1, 3'b100, 2,
                    32'hCAFE_BABE, 2'b10, 3'b100};
        vecs[1] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 0, 3'b100, 0,
                    32'h1111_2222, 2'b01, 3'b100};
        vecs[2] = '{32'h2000_0000, 1'b1, 32'hDEAD_0001, -1, 3'b000, 0,
                    32'h0, 2'b00, 3'b010};
        vecs[3] = '{32'h1FFF_FFFC, 1'b0, 32'h0, 1, 3'b010, 1,
                    32'h5555_AAAA, 2'b10, 3'b010};
        vecs[4] = '{32'h0FFF_FFFC, 1'b0, 32'h0, 0, 3'b001, 0,
                    32'h0F0F_0F0F, 2'b01, 3'b001};
        vecs[5] = '{32'hF000_0000, 1'b0, 32'h0, -1, 3'b000, 0,
                    32'h0, 2'b00, 3'b010};

        rst_n   = 1'b0;
        m_adr   = 32'h1000_0000;
        m_dat   = '0;
        m_sel   = 4'hF;
        m_we    = 1'b0;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_cti   = 3'b000;
        m_bte   = 2'b00;
        s_dat_i = '0;
        s_ack   = 2'b11;
        s_err   = 2'b00;
        s_rty   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", {62'd0, s_cyc}, 64'd0);
        chk("rst_stb", {62'd0, s_stb}, 64'd0);
        chk("rst_rsp", {61'd0, m_ack, m_err, m_rty}, 64'd0);
        idle_bus();
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        // incrementing burst of four to slave 0
        @(posedge clk); #1;
        m_adr = 32'h0000_0100;
        m_we  = 1'b0;
        m_cti = 3'b010;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            m_adr = 32'h0000_0100 + 32'(4 * b);
            m_cti = (b == 3) ? 3'b111 : 3'b010;
            s_ack[0] = 1'b1;
            s_dat_i[31:0] = 32'hB000_0000 + 32'(b);
            #1;
            chk("burst_stb", {62'd0, s_stb}, 64'd1);
            chk("burst_ack", {63'd0, m_ack}, 64'd1);
            chk("burst_dat", {32'd0, m_dat_o}, {32'd0, 32'hB000_0000 + 32'(b)});
        end
        @(posedge clk); #1;
        m_cti = 3'b000;
        #1;
        chk("burst_end_stb", {62'd0, s_stb}, 64'd0);
        chk("burst_end_ack", {63'd0, m_ack}, 64'd0);
        idle_bus();

`ifdef WB_MUX_TIMEOUT_EN
        // slave 0 never answers
        @(posedge clk); #1;
        m_adr = 32'h0000_0040;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c < 8) begin
                chk("tmo_wait_err", {63'd0, m_err}, 64'd0);
                chk("tmo_wait_cyc", {62'd0, s_cyc}, 64'd1);
            end else begin
                chk("tmo_err", {63'd0, m_err}, 64'd1);
                chk("tmo_cyc", {62'd0, s_cyc}, 64'd0);
                chk("tmo_stb", {62'd0, s_stb}, 64'd0);
            end
        end
        @(posedge clk); #1;
        chk("tmo_idle_stb", {62'd0, s_stb}, 64'd0);
        chk("tmo_idle_err", {63'd0, m_err}, 64'd0);
        idle_bus();
        apply(vecs[0]);

        // ack coincides with expiry
        @(posedge clk); #1;
        m_adr = 32'h0000_0040;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 8) s_ack[0] = 1'b1;
            #1;
            if (c == 8) begin
                chk("race_ack", {63'd0, m_ack}, 64'd1);
                chk("race_err", {63'd0, m_err}, 64'd0);
                chk("race_cyc", {62'd0, s_cyc}, 64'd1);
            end else begin
                chk("race_wait_err", {63'd0, m_err}, 64'd0);
            end
        end
        @(posedge clk); #1;
        s_ack = 2'b00;
        #1;
        chk("race_idle_stb", {62'd0, s_stb}, 64'd0);
        idle_bus();
`else
        // without the watchdog the transfer waits indefinitely
        @(posedge clk); #1;
        m_adr = 32'h0000_0040;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            chk("notmo_err", {63'd0, m_err}, 64'd0);
            chk("notmo_cyc", {62'd0, s_cyc}, 64'd1);
        end
        s_ack[0] = 1'b1;
        #1;
        chk("notmo_ack", {63'd0, m_ack}, 64'd1);
        @(posedge clk); #1;
        s_ack = 2'b00;
        idle_bus();
`endif

        // reset pulse while ACTIVE
        @(posedge clk); #1;
        m_adr = 32'h1000_0000;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_stb", {62'd0, s_stb}, 64'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_ack[1] = 1'b1;
        #1;
        chk("rst_mid_cyc", {62'd0, s_cyc}, 64'd0);
        chk("rst_mid_stb", {62'd0, s_stb}, 64'd0);
        chk("rst_mid_rsp", {61'd0, m_ack, m_err, m_rty}, 64'd0);
        idle_bus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
